// File: rtl/conv_result_packer.sv
// Output stage of the convolution datapath: buffers PE result vectors in a small FIFO
// and serialises them one extended lane per beat onto an AXI-Stream master with framing.
module conv_result_packer #(
    parameter int KERNEL_SIZE    = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int DEPTH          = 4,
    parameter int PTR_WIDTH      = 2,
    parameter int ROWS_PER_FRAME = 16
) (
    input  logic                                                           clk,
    input  logic                                                           rstn,
    input  logic [KERNEL_SIZE*(DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE)-1:0]   s_axis_tdata,
    input  logic                                                           s_axis_tvalid,
    output logic                                                           s_axis_tready,
    input  logic                                                           sign_ext,
    input  logic                                                           clear_err,
    output logic [BUS_WIDTH-1:0]                                           m_axis_tdata,
    output logic                                                           m_axis_tvalid,
    input  logic                                                           m_axis_tready,
    output logic                                                           m_axis_tlast,
    output logic                                                           overflow_err
);

    localparam int RW = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE;
    localparam int VW = KERNEL_SIZE * RW;
    localparam int LW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int FW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

    localparam logic [LW-1:0]        LANE_LAST  = LW'(KERNEL_SIZE - 1);
    localparam logic [FW-1:0]        FRAME_LAST = FW'(ROWS_PER_FRAME - 1);
    localparam logic [PTR_WIDTH:0]   FIFO_FULL  = (PTR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Sign- or zero-extend one RW-bit lane to the bus width.
    function automatic logic [BUS_WIDTH-1:0] extend_lane(input logic [RW-1:0] lane,
                                                         input logic          sext);
        logic [BUS_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < RW; i++) begin
            r[i] = lane[i];
        end
        for (int i = RW; i < BUS_WIDTH; i++) begin
            r[i] = sext & lane[RW-1];
        end
        return r;
    endfunction

    logic [VW-1:0]          mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]     count_q, count_d;
    state_e                 state_q, state_d;
    logic [VW-1:0]          vec_q, vec_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic                   sext_q, sext_d;
    logic [FW-1:0]          vec_cnt_q, vec_cnt_d;
    logic                   s_ready_q, s_ready_d;
    logic                   ovf_q, ovf_d;
    logic [BUS_WIDTH-1:0]   m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;

    logic                   push_s;
    logic                   drop_s;
    logic                   pop_s;
    logic                   fifo_empty_s;
    logic                   beat_s;

    // Handshake qualifiers; acceptance uses the registered ready so a pop cannot open a full FIFO.
    always_comb begin
        push_s       = s_axis_tvalid && s_ready_q;
        drop_s       = s_axis_tvalid && !s_ready_q;
        fifo_empty_s = (count_q == '0);
        beat_s       = m_valid_q && m_axis_tready;
    end

    // Serializer next-state: load on pop, step lanes on accepted beats, count vectors per frame.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        lane_d    = lane_q;
        sext_d    = sext_q;
        vec_cnt_d = vec_cnt_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_s) begin
                    if (lane_q != LANE_LAST) begin
                        lane_d = lane_q + 1'b1;
                    end else begin
                        vec_cnt_d = (vec_cnt_q == FRAME_LAST) ? '0 : vec_cnt_q + 1'b1;
                        if (!fifo_empty_s) begin
                            pop_s = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pop_s) begin
            vec_d  = mem_q[rd_ptr_q];
            lane_d = '0;
            sext_d = sign_ext;
        end else begin
            vec_d = vec_d;
        end
    end

    // FIFO pointers/occupancy, input ready and the sticky drop flag.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        s_ready_d = (count_d < FIFO_FULL);
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Output beat is computed from next state so outputs stay registered and hold while stalled.
    always_comb begin
        m_valid_d = (state_d == ST_SEND);
        if (m_valid_d) begin
            m_data_d = extend_lane(vec_d[int'(lane_d)*RW +: RW], sext_d);
        end else begin
            m_data_d = '0;
        end
        m_last_d = m_valid_d && (lane_d == LANE_LAST) && (vec_cnt_d == FRAME_LAST);
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            lane_q    <= '0;
            sext_q    <= 1'b0;
            vec_cnt_q <= '0;
            s_ready_q <= 1'b0;
            ovf_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            lane_q    <= lane_d;
            sext_q    <= sext_d;
            vec_cnt_q <= vec_cnt_d;
            s_ready_q <= s_ready_d;
            ovf_q     <= ovf_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign overflow_err  = ovf_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_conv_result_packer.sv
// Directed bench for conv_result_packer: reset, extension, framing, overflow, stalls, reset mid-vector.
module tb_conv_result_packer;

    localparam int K   = 3;
    localparam int RW  = 19;
    localparam int BW  = 32;
    localparam int VW  = K * RW;
    localparam int RPF = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [VW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          sign_ext = 1'b1;
    logic          clear_err = 1'b0;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          overflow_err;

    int checks = 0;
    int failures = 0;

    logic [VW-1:0] vecs [0:127];
    logic [BW-1:0] got_data [$];
    logic          got_last [$];
    int            got_cyc [$];
    int            stable_bad;

    conv_result_packer dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .sign_ext     (sign_ext),
        .clear_err    (clear_err),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] model_ext(input logic [RW-1:0] v, input logic sx);
        logic signed [RW-1:0] s;
        s = v;
        return sx ? BW'(s) : {13'd0, v};
    endfunction

    function automatic logic [RW-1:0] lane_of(input logic [VW-1:0] v, input int l);
        return v[l*RW +: RW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        s_axis_tvalid = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Drives n vectors starting at vecs[first], one every gap cycles, only while ready is high.
    task automatic push_vecs(input int first, input int n, input int gap);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (s_axis_tready !== 1'b1 && w < 500) begin
                @(negedge clk);
                w++;
            end
            s_axis_tdata = vecs[first+i];
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            for (int g = 1; g < gap; g++) @(negedge clk);
        end
    endtask

    // Records accepted beats with the negedge index they appeared on; counts unstable stalled beats.
    task automatic collect_beats(input int n, input int stall_pct, input int budget);
        logic          held = 1'b0;
        logic [BW-1:0] hd = '0;
        logic          hl = 1'b0;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        stable_bad = 0;
        for (int c = 0; c < budget && got_data.size() < n; c++) begin
            @(negedge clk);
            if (held && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tlast !== hl))
                stable_bad++;
            m_axis_tready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
            held = 1'b0;
            if (m_axis_tvalid === 1'b1) begin
                if (m_axis_tready) begin
                    got_data.push_back(m_axis_tdata);
                    got_last.push_back(m_axis_tlast);
                    got_cyc.push_back(c);
                end else begin
                    held = 1'b1;
                    hd = m_axis_tdata;
                    hl = m_axis_tlast;
                end
            end
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 ||
            m_axis_tlast !== 1'b0 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b ovf=%b expected 0 0 00000000 0 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow_err);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after: got %b expected 1", s_axis_tready);
        end
    endtask

    task automatic test_sign_ext();
        logic [BW-1:0] exp [3];
        exp[0] = 32'h00000001; exp[1] = 32'hFFFFFFFF; exp[2] = 32'hFFFC0000;
        m_axis_tready = 1'b1;
        sign_ext = 1'b1;
        @(negedge clk);
        s_axis_tdata = {19'h40000, 19'h7FFFF, 19'h00001};
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL sx_no_bypass: got tvalid=%b expected 0", m_axis_tvalid);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp[b] || m_axis_tlast !== 1'b0) begin
                failures++;
                $display("FAIL sx_beat%0d: got vld=%b data=%h last=%b expected 1 %h 0",
                         b, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp[b]);
            end
            sign_ext = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL sx_idle_after: got tvalid=%b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_zero_ext();
        logic [BW-1:0] exp [3];
        exp[0] = 32'h00000001; exp[1] = 32'h0007FFFF; exp[2] = 32'h00040000;
        sign_ext = 1'b0;
        vecs[127] = {19'h40000, 19'h7FFFF, 19'h00001};
        fork
            push_vecs(127, 1, 1);
            collect_beats(3, 0, 20);
        join
        checks++;
        if (got_data.size() != 3) begin
            failures++;
            $display("FAIL zx_count: got %0d beats expected 3", got_data.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (got_data[b] !== exp[b] || got_last[b] !== 1'b0) begin
                    failures++;
                    $display("FAIL zx_beat%0d: got %h last=%b expected %h 0", b, got_data[b], got_last[b], exp[b]);
                end
            end
        end
        sign_ext = 1'b1;
    endtask

    task automatic test_frame();
        int bad_data = 0;
        int bad_last = 0;
        int gaps = 0;
        do_reset();
        sign_ext = 1'b1;
        fork
            push_vecs(0, 17, 3);
            collect_beats(51, 0, 300);
        join
        checks++;
        if (got_data.size() != 51) begin
            failures++;
            $display("FAIL frame_count: got %0d beats expected 51", got_data.size());
        end else begin
            for (int i = 0; i < 51; i++) begin
                if (got_data[i] !== model_ext(lane_of(vecs[i/3], i%3), 1'b1)) bad_data++;
                if (got_last[i] !== (i == 47)) bad_last++;
                if (got_cyc[i] != got_cyc[0] + i) gaps++;
            end
            checks++;
            if (bad_data != 0) begin
                failures++;
                $display("FAIL frame_data: got %0d wrong beats expected 0", bad_data);
            end
            checks++;
            if (bad_last != 0 || got_last[47] !== 1'b1 || got_last[50] !== 1'b0) begin
                failures++;
                $display("FAIL frame_tlast: got %0d wrong, beat48=%b beat51=%b expected 0 1 0",
                         bad_last, got_last[47], got_last[50]);
            end
            checks++;
            if (gaps != 0) begin
                failures++;
                $display("FAIL frame_no_gaps: got %0d gaps expected 0", gaps);
            end
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        do_reset();
        sign_ext = 1'b1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata = vecs[40+i];
            s_axis_tvalid = 1'b1;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b0 || overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full: got rdy=%b ovf=%b expected 0 1", s_axis_tready, overflow_err);
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== model_ext(lane_of(vecs[40], 0), 1'b1)) begin
            failures++;
            $display("FAIL ovf_stalled_head: got vld=%b data=%h expected 1 %h",
                     m_axis_tvalid, m_axis_tdata, model_ext(lane_of(vecs[40], 0), 1'b1));
        end
        s_axis_tdata = vecs[50];
        s_axis_tvalid = 1'b1;
        clear_err = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        clear_err = 1'b0;
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow_err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow_err);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b expected 0", overflow_err);
        end
        collect_beats(15, 0, 60);
        checks++;
        if (got_data.size() != 15) begin
            failures++;
            $display("FAIL ovf_drain_count: got %0d beats expected 15", got_data.size());
        end else begin
            for (int i = 0; i < 15; i++)
                if (got_data[i] !== model_ext(lane_of(vecs[40+i/3], i%3), 1'b1) || got_last[i] !== 1'b0) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL ovf_drain_order: got %0d wrong beats expected 0", bad);
            end
        end
    endtask

    task automatic test_random_stall();
        int bad = 0;
        do_reset();
        sign_ext = 1'b1;
        fork
            push_vecs(0, 100, 1);
            collect_beats(300, 40, 4000);
        join
        checks++;
        if (got_data.size() != 300) begin
            failures++;
            $display("FAIL stall_count: got %0d beats expected 300", got_data.size());
        end else begin
            for (int i = 0; i < 300; i++)
                if (got_data[i] !== model_ext(lane_of(vecs[i/3], i%3), 1'b1) ||
                    got_last[i] !== ((i/3) % RPF == RPF-1 && i%3 == 2)) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL stall_data: got %0d wrong beats expected 0", bad);
            end
        end
        checks++;
        if (stable_bad != 0) begin
            failures++;
            $display("FAIL stall_stable: got %0d changes while stalled expected 0", stable_bad);
        end
    endtask

    task automatic test_reset_mid_vector();
        int  bad = 0;
        int  extra = 0;
        bit  found = 1'b0;
        do_reset();
        sign_ext = 1'b1;
        fork
            push_vecs(0, 15, 1);
            collect_beats(45, 0, 300);
        join
        @(negedge clk);
        s_axis_tdata = vecs[20];
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tdata = vecs[21];
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (m_axis_tvalid === 1'b1 && m_axis_tdata === model_ext(lane_of(vecs[20], 1), 1'b1)) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_mid_lane1: got no lane-1 beat expected %h", model_ext(lane_of(vecs[20], 1), 1'b1));
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_cleared: got vld=%b data=%h last=%b expected 0 00000000 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        rstn = 1'b1;
        @(negedge clk);
        fork
            push_vecs(30, 1, 1);
            collect_beats(3, 0, 20);
        join
        checks++;
        if (got_data.size() != 3) begin
            failures++;
            $display("FAIL rst_mid_count: got %0d beats expected 3", got_data.size());
        end else begin
            for (int i = 0; i < 3; i++)
                if (got_data[i] !== model_ext(lane_of(vecs[30], i), 1'b1) || got_last[i] !== 1'b0) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rst_mid_new_vector: got %0d wrong beats expected 0", bad);
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL rst_mid_discard: got %0d stale beats expected 0", extra);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            vecs[i] = {19'(i*2731 + 32'h40000), 19'(32'h7FFFF - i*313), 19'(i*4099 + 1)};
        test_reset();
        test_sign_ext();
        test_zero_ext();
        test_frame();
        test_overflow();
        test_random_stall();
        test_reset_mid_vector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
